alarm_ring_ctrl: RTL and testbench

Upstream control stage for the melody player. Compares the running clock time against a programmed alarm time and produces the `play` gate that drives the player's enable input.
- Owns ringing duration, snooze and stop handling for the digital clock.
- Time inputs come from the timekeeping counters; the stop and snooze buttons arrive already debounced as single-cycle pulses.

---
 rtl/alarm_ring_ctrl_pkg.sv | 15 +
 rtl/alarm_ring_ctrl_sec_prescaler.sv | 34 +++
 rtl/alarm_ring_ctrl.sv | 125 ++++++++++++
 tb/tb_alarm_ring_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_ring_ctrl_pkg.sv
// Shared types and field widths for the alarm ring controller and the timekeeping blocks.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } state_e;

   localparam int HOUR_W       = 5;
   localparam int MIN_W        = 6;
   localparam int SEC_W        = 6;
   localparam int SNOOZE_CNT_W = 2;

endpackage

// File: rtl/alarm_ring_ctrl_sec_prescaler.sv
// Divides sys_CLK down to a one-cycle sec_tick every CLK_HZ cycles; clr restarts the count.
// sec_tick is a decode of the registered count, so it is safe to feed back into next-state logic.
module sec_prescaler #(
   parameter int CLK_HZ = 100000000
) (
   input  logic sys_CLK,
   input  logic rst,
   input  logic clr,
   output logic sec_tick
);

   localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clr || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge sys_CLK) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sec_tick = (cnt_q == LAST);

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: fires on the rising edge of an alarm-time match, times ringing and snooze,
// and drives the melody player's play gate one edge after the first matching cycle.
module alarm_ring_ctrl
   import alarm_pkg::*;
#(
   parameter int CLK_HZ     = 100000000,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int MAX_SNOOZE = 3
) (
   input  logic                    sys_CLK,
   input  logic                    rst,
   input  logic [HOUR_W-1:0]       hour,
   input  logic [MIN_W-1:0]        minute,
   input  logic [SEC_W-1:0]        second,
   input  logic [HOUR_W-1:0]       alarm_hour,
   input  logic [MIN_W-1:0]        alarm_minute,
   input  logic                    alarm_en,
   input  logic                    stop_pulse,
   input  logic                    snooze_pulse,
   output logic                    play,
   output logic                    snoozing,
   output logic [SNOOZE_CNT_W-1:0] snooze_left
);

   localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
   localparam int SCNT_W  = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;
   localparam logic [SCNT_W-1:0]       RING_LAST   = SCNT_W'(RING_SEC - 1);
   localparam logic [SCNT_W-1:0]       SNOOZE_LAST = SCNT_W'(SNOOZE_SEC - 1);
   localparam logic [SNOOZE_CNT_W-1:0] SNOOZE_MAX  = SNOOZE_CNT_W'(MAX_SNOOZE);

   state_e                  state_q, state_d;
   logic [SCNT_W-1:0]       sec_cnt_q, sec_cnt_d;
   logic [SNOOZE_CNT_W-1:0] snooze_left_q, snooze_left_d;
   logic                    match, match_q, match_rise;
   logic                    sec_tick, clr;
   logic                    play_q, snoozing_q;

   assign match      = alarm_en & (hour == alarm_hour) & (minute == alarm_minute) & (second == '0);
   assign match_rise = match & ~match_q;

   always_comb begin
      state_d       = state_q;
      snooze_left_d = snooze_left_q;
      case (state_q)
         IDLE: begin
            if (match_rise) begin
               state_d       = RING;
               snooze_left_d = SNOOZE_MAX;
            end
         end
         RING: begin
            if (stop_pulse) begin
               state_d = IDLE;
            end else if (snooze_pulse) begin
               if (snooze_left_q != '0) begin
                  state_d       = SNOOZE;
                  snooze_left_d = snooze_left_q - SNOOZE_CNT_W'(1);
               end else begin
                  state_d = IDLE;
               end
            end else if (sec_tick && (sec_cnt_q == RING_LAST)) begin
               state_d = IDLE;
            end
         end
         SNOOZE: begin
            if (stop_pulse) begin
               state_d = IDLE;
            end else if ((sec_tick && (sec_cnt_q == SNOOZE_LAST)) || match_rise) begin
               state_d = RING;
            end
         end
         default: state_d = IDLE;
      endcase
      // Disarming overrides everything below reset, including a pending snooze decrement.
      if (!alarm_en) begin
         state_d       = IDLE;
         snooze_left_d = snooze_left_q;
      end
   end

   // Restarting the time base on every state entry makes each state last whole seconds.
   assign clr = (state_d != state_q);

   always_comb begin
      sec_cnt_d = sec_cnt_q;
      if (clr || (state_q == IDLE)) begin
         sec_cnt_d = '0;
      end else if (sec_tick) begin
         sec_cnt_d = sec_cnt_q + SCNT_W'(1);
      end
   end

   sec_prescaler #(
      .CLK_HZ(CLK_HZ)
   ) u_sec_prescaler (
      .sys_CLK  (sys_CLK),
      .rst      (rst),
      .clr      (clr),
      .sec_tick (sec_tick)
   );

   always_ff @(posedge sys_CLK) begin
      if (rst) begin
         state_q       <= IDLE;
         sec_cnt_q     <= '0;
         snooze_left_q <= SNOOZE_MAX;
         match_q       <= 1'b0;
         play_q        <= 1'b0;
         snoozing_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         sec_cnt_q     <= sec_cnt_d;
         snooze_left_q <= snooze_left_d;
         match_q       <= match;
         play_q        <= (state_d == RING);
         snoozing_q    <= (state_d == SNOOZE);
      end
   end

   assign play        = play_q;
   assign snoozing    = snoozing_q;
   assign snooze_left = snooze_left_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Bench for alarm_ring_ctrl: directed vector table, a ring-length count, then random traffic vs a cycle-count model.
module tb_alarm_ring_ctrl;

   localparam int HZ = 10;
   localparam int RS = 3;
   localparam int SS = 2;
   localparam int MX = 2;

   logic       sys_CLK = 1'b0;
   logic       rst;
   logic [4:0] hour, alarm_hour;
   logic [5:0] minute, second, alarm_minute;
   logic       alarm_en, stop_pulse, snooze_pulse;
   logic       play, snoozing;
   logic [1:0] snooze_left;

   always #5 sys_CLK = ~sys_CLK;

   alarm_ring_ctrl #(
      .CLK_HZ(HZ), .RING_SEC(RS), .SNOOZE_SEC(SS), .MAX_SNOOZE(MX)
   ) dut (
      .sys_CLK      (sys_CLK),
      .rst          (rst),
      .hour         (hour),
      .minute       (minute),
      .second       (second),
      .alarm_hour   (alarm_hour),
      .alarm_minute (alarm_minute),
      .alarm_en     (alarm_en),
      .stop_pulse   (stop_pulse),
      .snooze_pulse (snooze_pulse),
      .play         (play),
      .snoozing     (snoozing),
      .snooze_left  (snooze_left)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0=silent, 1=ringing, 2=snoozing; elapsed counts edges spent in the mode.
   int m_mode = 0, m_elapsed = 0, m_left = MX;
   bit m_prev = 1'b0;

   task automatic model_edge();
      bit mt, rise;
      int nm;
      mt   = alarm_en && (hour == alarm_hour) && (minute == alarm_minute) && (second == 0);
      rise = mt && !m_prev;
      if (rst) begin
         m_mode = 0; m_elapsed = 0; m_left = MX; m_prev = 1'b0;
         return;
      end
      m_prev = mt;
      nm = m_mode;
      if (!alarm_en) nm = 0;
      else if (m_mode == 1) begin
         if (stop_pulse) nm = 0;
         else if (snooze_pulse) begin
            if (m_left > 0) begin nm = 2; m_left = m_left - 1; end
            else nm = 0;
         end else if (m_elapsed == RS * HZ - 1) nm = 0;
      end else if (m_mode == 2) begin
         if (stop_pulse) nm = 0;
         else if ((m_elapsed == SS * HZ - 1) || rise) nm = 1;
      end else if (rise) begin
         nm = 1; m_left = MX;
      end
      m_elapsed = (nm != m_mode) ? 0 : m_elapsed + 1;
      m_mode    = nm;
   endtask

   task automatic tick();
      model_edge();
      @(posedge sys_CLK);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   typedef struct {
      bit r, en;
      int h, m, s;
      bit st, sn;
      int n;
      bit e_play, e_snz;
      int e_left;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit r, bit en, int h, int m, int s, bit st, bit sn, int n,
                               bit ep, bit es, int el);
      vec_t v;
      v.r = r; v.en = en; v.h = h; v.m = m; v.s = s; v.st = st; v.sn = sn; v.n = n;
      v.e_play = ep; v.e_snz = es; v.e_left = el;
      return v;
   endfunction

   task automatic set_time(input int h, input int m, input int s);
      hour = 5'(h); minute = 6'(m); second = 6'(s);
   endtask

   initial begin
      int cnt;
      rst = 1'b1; alarm_en = 1'b1; stop_pulse = 1'b0; snooze_pulse = 1'b0;
      alarm_hour = 5'd7; alarm_minute = 6'd30;
      set_time(7, 29, 59);

      // reset
      tbl.push_back(mk(1,1,7,29,59,0,0, 2, 0,0,2));
      // basic fire, 30 cycles of ringing, no re-fire while 07:30:00 is held
      tbl.push_back(mk(0,1,7,29,59,0,0, 3, 0,0,2));
      tbl.push_back(mk(0,1,7,30, 0,0,0, 1, 1,0,2));
      tbl.push_back(mk(0,1,7,30, 0,0,0,29, 1,0,2));
      tbl.push_back(mk(0,1,7,30, 0,0,0, 1, 0,0,2));
      tbl.push_back(mk(0,1,7,30, 0,0,0,10, 0,0,2));
      // stop at ring cycle 5
      tbl.push_back(mk(0,1,7,29,59,0,0, 2, 0,0,2));
      tbl.push_back(mk(0,1,7,30, 0,0,0, 1, 1,0,2));
      tbl.push_back(mk(0,1,7,30, 1,0,0, 4, 1,0,2));
      tbl.push_back(mk(0,1,7,30, 1,1,0, 1, 0,0,2));
      tbl.push_back(mk(0,1,7,30, 1,0,0, 3, 0,0,2));
      // snooze twice, third snooze stops
      tbl.push_back(mk(0,1,7,29,59,0,0, 2, 0,0,2));
      tbl.push_back(mk(0,1,7,30, 0,0,0, 1, 1,0,2));
      tbl.push_back(mk(0,1,7,30, 1,0,0, 3, 1,0,2));
      tbl.push_back(mk(0,1,7,30, 1,0,1, 1, 0,1,1));
      tbl.push_back(mk(0,1,7,30, 1,0,0,19, 0,1,1));
      tbl.push_back(mk(0,1,7,30, 1,0,0, 1, 1,0,1));
      tbl.push_back(mk(0,1,7,30, 1,0,1, 1, 0,1,0));
      tbl.push_back(mk(0,1,7,30, 1,0,0,20, 1,0,0));
      tbl.push_back(mk(0,1,7,30, 1,0,1, 1, 0,0,0));
      tbl.push_back(mk(0,1,7,30, 1,0,0, 5, 0,0,0));
      // stop and snooze together: stop wins, snooze_left kept
      tbl.push_back(mk(0,1,7,29,59,0,0, 2, 0,0,0));
      tbl.push_back(mk(0,1,7,30, 0,0,0, 1, 1,0,2));
      tbl.push_back(mk(0,1,7,30, 1,0,0, 1, 1,0,2));
      tbl.push_back(mk(0,1,7,30, 1,0,1, 1, 0,1,1));
      tbl.push_back(mk(0,1,7,30, 1,0,0,20, 1,0,1));
      tbl.push_back(mk(0,1,7,30, 1,1,1, 1, 0,0,1));
      tbl.push_back(mk(0,1,7,30, 1,0,0, 3, 0,0,1));
      // disarm during snooze, re-arm off-match, fire on next rise
      tbl.push_back(mk(0,1,7,29,59,0,0, 2, 0,0,1));
      tbl.push_back(mk(0,1,7,30, 0,0,0, 1, 1,0,2));
      tbl.push_back(mk(0,1,7,30, 1,0,0, 1, 1,0,2));
      tbl.push_back(mk(0,1,7,30, 1,0,1, 1, 0,1,1));
      tbl.push_back(mk(0,1,7,30, 1,0,0, 5, 0,1,1));
      tbl.push_back(mk(0,0,7,30, 1,0,0, 1, 0,0,1));
      tbl.push_back(mk(0,1,7,31, 0,0,0, 5, 0,0,1));
      tbl.push_back(mk(0,1,7,30, 0,0,0, 1, 1,0,2));
      // reset at ring cycle 7, no re-ring, then a clean full-length ring
      tbl.push_back(mk(0,1,7,30, 1,0,0, 6, 1,0,2));
      tbl.push_back(mk(1,1,7,30, 1,0,0, 1, 0,0,2));
      tbl.push_back(mk(0,1,7,30, 1,0,0,40, 0,0,2));
      tbl.push_back(mk(0,1,7,30, 0,0,0, 1, 1,0,2));
      tbl.push_back(mk(0,1,7,30, 1,0,0,29, 1,0,2));
      tbl.push_back(mk(0,1,7,30, 1,0,0, 1, 0,0,2));
      // match during snooze rings immediately without reloading snooze_left
      tbl.push_back(mk(0,1,7,29,59,0,0, 2, 0,0,2));
      tbl.push_back(mk(0,1,7,30, 0,0,0, 1, 1,0,2));
      tbl.push_back(mk(0,1,7,30, 1,0,0, 1, 1,0,2));
      tbl.push_back(mk(0,1,7,30, 1,0,1, 1, 0,1,1));
      tbl.push_back(mk(0,1,7,29,59,0,0, 3, 0,1,1));
      tbl.push_back(mk(0,1,7,30, 0,0,0, 1, 1,0,1));

      foreach (tbl[i]) begin
         rst = tbl[i].r; alarm_en = tbl[i].en;
         set_time(tbl[i].h, tbl[i].m, tbl[i].s);
         stop_pulse = tbl[i].st; snooze_pulse = tbl[i].sn;
         repeat (tbl[i].n) tick();
         chk($sformatf("vec%0d_play", i), int'(play), int'(tbl[i].e_play));
         chk($sformatf("vec%0d_snoozing", i), int'(snoozing), int'(tbl[i].e_snz));
         chk($sformatf("vec%0d_snooze_left", i), int'(snooze_left), tbl[i].e_left);
      end
      rst = 1'b0; stop_pulse = 1'b0; snooze_pulse = 1'b0;

      // Ring length measured by counting play-high samples, bounded.
      stop_pulse = 1'b1; tick(); stop_pulse = 1'b0;
      set_time(7, 29, 59); tick(); tick();
      set_time(7, 30, 0); tick();
      set_time(7, 30, 1);
      cnt = 0;
      for (int i = 0; i < 100 && play; i++) begin
         cnt++;
         tick();
      end
      chk("ring_len", cnt, RS * HZ);

      // Random traffic against the model.
      rst = 1'b1; tick(); rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0: set_time(7, 30, 0);
               1: set_time(7, 30, int'($urandom_range(1, 59)));
               2: set_time(7, 31, 0);
               default: set_time(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                                 int'($urandom_range(0, 63)));
            endcase
         end
         if (alarm_en) alarm_en = ($urandom_range(0, 199) != 0);
         else          alarm_en = ($urandom_range(0, 4) == 0);
         stop_pulse   = ($urandom_range(0, 39) == 0);
         snooze_pulse = ($urandom_range(0, 11) == 0);
         rst          = ($urandom_range(0, 499) == 0);
         tick();
         chk("rand_play", int'(play), (m_mode == 1) ? 1 : 0);
         chk("rand_snoozing", int'(snoozing), (m_mode == 2) ? 1 : 0);
         chk("rand_snooze_left", int'(snooze_left), m_left);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
